// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared op codes, state encodings and step width for the I2C sensor sequencer
package i2c_pkg;

  // Command codes presented to the byte-level I2C master
  localparam logic [2:0] OP_NONE      = 3'd0;
  localparam logic [2:0] OP_START     = 3'd1;
  localparam logic [2:0] OP_STOP      = 3'd2;
  localparam logic [2:0] OP_WRITE     = 3'd3;
  localparam logic [2:0] OP_READ_ACK  = 3'd4;
  localparam logic [2:0] OP_READ_NACK = 3'd5;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_CFG   = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  // Longest step list (RD) has eight entries
  localparam int STEP_W = 3;
  typedef logic [STEP_W-1:0] step_t;

  // One entry of a step list
  typedef struct packed {
    logic [2:0] code;
    logic [7:0] wdata;
    logic       last_step;
  } op_t;

  // Error counter increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_sensor_sequencer_if.sv
// rtl/i2c_sensor_sequencer_if.sv - command handshake between the sequencer and the I2C byte master
interface i2c_sensor_sequencer_if;
  logic       op_req;
  logic [2:0] op_code;
  logic [7:0] op_wdata;
  logic       op_done;
  logic [7:0] op_rdata;
  logic       op_nack;

  modport master (output op_req, op_code, op_wdata, input op_done, op_rdata, op_nack);
  modport slave  (input op_req, op_code, op_wdata, output op_done, op_rdata, op_nack);
endinterface

// File: rtl/i2c_op_timer.sv
// rtl/i2c_op_timer.sv - per-op timeout counter, restarted on each op launch
module i2c_op_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count equals the number of cycles the op has been outstanding, so
  // the last cycle an op_done can still be accepted is TIMEOUT-1.
  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  // Restart on launch, count while the op is outstanding, park at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/i2c_sensor_sequencer.sv
// rtl/i2c_sensor_sequencer.sv - configures the 16-bit sensor once, then samples it periodically
module i2c_sensor_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter logic [7:0]  CFG_PTR  = 8'h01,
  parameter logic [15:0] CFG_VAL  = 16'h60A0,
  parameter logic [7:0]  DATA_PTR = 8'h00,
  parameter int          PERIOD   = 1000,
  parameter int          TIMEOUT  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  i2c_sensor_sequencer_if.master bus,
  output logic [15:0]            dout,
  output logic                   sample_valid,
  output logic                   cfg_done,
  output logic                   busy,
  output logic [7:0]             err_count
);
  localparam int         PW     = $clog2(PERIOD + 1);
  localparam logic [7:0] ADDR_W = {DEV_ADDR, 1'b0};
  localparam logic [7:0] ADDR_R = {DEV_ADDR, 1'b1};

  state_t        state_q, state_d;
  step_t         step_q, step_d;
  logic          op_req_q, op_req_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [7:0]    op_wdata_q, op_wdata_d;
  logic [PW-1:0] per_q, per_d;
  logic [7:0]    msb_q, msb_d, lsb_q, lsb_d;
  logic [15:0]   dout_q, dout_d;
  logic          sv_q, sv_d;
  logic          cfg_q, cfg_d;
  logic [7:0]    err_q, err_d;

  op_t  cur_op;
  logic done, timeout, expired, launch;

  // Step lists, indexed by the active sequence and its position
  function automatic op_t step_op(input state_t st, input step_t idx);
    op_t o;
    o = '{code: OP_NONE, wdata: 8'h00, last_step: 1'b0};
    case ({st, idx})
      {ST_CFG, 3'd0}:   o.code = OP_START;
      {ST_CFG, 3'd1}:   begin o.code = OP_WRITE; o.wdata = ADDR_W;        end
      {ST_CFG, 3'd2}:   begin o.code = OP_WRITE; o.wdata = CFG_PTR;       end
      {ST_CFG, 3'd3}:   begin o.code = OP_WRITE; o.wdata = CFG_VAL[15:8]; end
      {ST_CFG, 3'd4}:   begin o.code = OP_WRITE; o.wdata = CFG_VAL[7:0];  end
      {ST_CFG, 3'd5}:   begin o.code = OP_STOP;  o.last_step = 1'b1;      end
      {ST_RD, 3'd0}:    o.code = OP_START;
      {ST_RD, 3'd1}:    begin o.code = OP_WRITE; o.wdata = ADDR_W;        end
      {ST_RD, 3'd2}:    begin o.code = OP_WRITE; o.wdata = DATA_PTR;      end
      {ST_RD, 3'd3}:    o.code = OP_START;
      {ST_RD, 3'd4}:    begin o.code = OP_WRITE; o.wdata = ADDR_R;        end
      {ST_RD, 3'd5}:    o.code = OP_READ_ACK;
      {ST_RD, 3'd6}:    o.code = OP_READ_NACK;
      {ST_RD, 3'd7}:    begin o.code = OP_STOP;  o.last_step = 1'b1;      end
      {ST_ABORT, 3'd0}: begin o.code = OP_STOP;  o.last_step = 1'b1;      end
      default:          ;
    endcase
    return o;
  endfunction

  assign cur_op  = step_op(state_q, step_q);
  assign done    = op_req_q && bus.op_done;
  assign timeout = op_req_q && !bus.op_done && expired;
  assign launch  = op_req_d && !op_req_q;

  i2c_op_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (launch),
    .run_i     (op_req_q),
    .expired_o (expired)
  );

  // Sequencing: period wait, op launch one cycle after the previous op drops,
  // completion / NACK / timeout handling
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    op_req_d   = op_req_q;
    op_code_d  = op_code_q;
    op_wdata_d = op_wdata_q;
    per_d      = per_q;
    msb_d      = msb_q;
    lsb_d      = lsb_q;
    dout_d     = dout_q;
    sv_d       = 1'b0;
    cfg_d      = cfg_q;
    err_d      = err_q;
    if (state_q == ST_WAIT) begin
      if (enable) begin
        if (per_q == PW'(PERIOD - 1)) begin
          // START is launched on the exit edge so busy and op_req rise together
          per_d      = '0;
          state_d    = cfg_q ? ST_RD : ST_CFG;
          step_d     = '0;
          op_req_d   = 1'b1;
          op_code_d  = OP_START;
          op_wdata_d = 8'h00;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
    end else if (!op_req_q) begin
      op_req_d   = 1'b1;
      op_code_d  = cur_op.code;
      op_wdata_d = cur_op.wdata;
    end else if (done) begin
      op_req_d   = 1'b0;
      op_code_d  = OP_NONE;
      op_wdata_d = 8'h00;
      if (op_code_q == OP_READ_ACK)  msb_d = bus.op_rdata;
      if (op_code_q == OP_READ_NACK) lsb_d = bus.op_rdata;
      if (op_code_q == OP_WRITE && bus.op_nack) begin
        err_d   = sat_inc8(err_q);
        state_d = ST_ABORT;
        step_d  = '0;
      end else if (cur_op.last_step) begin
        state_d = ST_WAIT;
        step_d  = '0;
        per_d   = '0;
        if (state_q == ST_CFG) cfg_d = 1'b1;
        if (state_q == ST_RD) begin
          dout_d = {msb_q, lsb_q};
          sv_d   = 1'b1;
        end
      end else begin
        step_d = step_q + 1'b1;
      end
    end else if (timeout) begin
      // No STOP after a timeout: the bus is presumed wedged
      op_req_d   = 1'b0;
      op_code_d  = OP_NONE;
      op_wdata_d = 8'h00;
      err_d      = sat_inc8(err_q);
      state_d    = ST_WAIT;
      step_d     = '0;
      per_d      = '0;
    end
  end

  // State registers; reset overrides any same-cycle op_done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      step_q     <= '0;
      op_req_q   <= 1'b0;
      op_code_q  <= OP_NONE;
      op_wdata_q <= 8'h00;
      per_q      <= '0;
      msb_q      <= 8'h00;
      lsb_q      <= 8'h00;
      dout_q     <= 16'h0000;
      sv_q       <= 1'b0;
      cfg_q      <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_req_q   <= op_req_d;
      op_code_q  <= op_code_d;
      op_wdata_q <= op_wdata_d;
      per_q      <= per_d;
      msb_q      <= msb_d;
      lsb_q      <= lsb_d;
      dout_q     <= dout_d;
      sv_q       <= sv_d;
      cfg_q      <= cfg_d;
      err_q      <= err_d;
    end
  end

  assign bus.op_req   = op_req_q;
  assign bus.op_code  = op_code_q;
  assign bus.op_wdata = op_wdata_q;
  assign dout         = dout_q;
  assign sample_valid = sv_q;
  assign cfg_done     = cfg_q;
  assign busy         = (state_q != ST_WAIT);
  assign err_count    = err_q;
endmodule
